// File: rtl/mem_port_arbiter.sv
// +---------------------------------------------------------------------------+
// | mem_port_arbiter                                                          |
// | Shares one synchronous memory port between byte fetch and 32-bit data.    |
// | Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.                |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [7:0]        f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(3);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic        fetch_pri;
  logic        f_gnt_w, d_gnt_w;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!f_req || f_gnt_w) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign fetch_pri = (starve_q >= 4'(STARVE_LIMIT));
`else
  assign fetch_pri = 1'b0;
`endif

  // Grants never look at mem_rdata, so the port drive has no path from it.
  always_comb begin
    f_gnt_w = 1'b0;
    d_gnt_w = 1'b0;
    if (!reset) begin
      if (f_req && (!d_req || fetch_pri)) begin
        f_gnt_w = 1'b1;
      end else if (d_req) begin
        d_gnt_w = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    lane_d  = lane_q;
    if (f_gnt_w) begin
      state_d = RESP_F;
      lane_d  = f_addr[1:0];
    end else if (d_gnt_w && !d_we) begin
      state_d = RESP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    f_gnt     = f_gnt_w;
    d_gnt     = d_gnt_w;
    mem_en    = f_gnt_w | d_gnt_w;
    mem_we    = d_gnt_w & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    f_rvalid  = 1'b0;
    f_rdata   = 8'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    if (f_gnt_w) begin
      mem_addr = f_addr & C_WORD_MASK;
    end else if (d_gnt_w) begin
      mem_addr = d_addr & C_WORD_MASK;
    end
    if (!reset) begin
      mem_wdata = d_wdata;
      // A response pending across a reset cycle is dropped here.
      if (state_q == RESP_F) begin
        f_rvalid = 1'b1;
        case (lane_q)
          2'd0:    f_rdata = mem_rdata[7:0];
          2'd1:    f_rdata = mem_rdata[15:8];
          2'd2:    f_rdata = mem_rdata[23:16];
          default: f_rdata = mem_rdata[31:24];
        endcase
      end
      if (state_q == RESP_D) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single synchronous memory port between the byte-wide instruction fetch path and the 32-bit M-stage data path. Each cycle it grants at most one requester and drives the memory port from the winner. It routes the read response back to the correct requester one cycle later. Data access has priority by default; an optional starvation guard bounds fetch latency.

## Interface
- `ADDR_W`, default 32: address width for both requesters and the memory.
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles before fetch wins (starvation guard only); legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `f_req` in 1: fetch read request.
- `f_addr` in ADDR_W: fetch byte address.
- `f_gnt` out 1: fetch request accepted this cycle.
- `f_rvalid` out 1: `f_rdata` valid.
- `f_rdata` out 8: fetched byte.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data word address; bits [1:0] are ignored.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: `d_rdata` valid.
- `d_rdata` out 32: read word.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: word-aligned address (bits [1:0] = 0).
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after a read with `mem_en`=1.

## Operation
- Requester protocol:
  - A requester holds req, addr, we and wdata stable until gnt is seen high on a rising edge.
  - gnt is combinational from req and arbiter state, in the same cycle.
- Arbitration:
  - Only `d_req`: data wins.
  - Only `f_req`: fetch wins.
  - Both: data wins, unless the starvation guard is active (see Configuration).
  - The grant depends only on registered state and the current cycle's requests, never on `mem_rdata`.
- Memory port drive:
  - `mem_en` = `f_gnt` | `d_gnt`.
  - `mem_we` = `d_gnt` & `d_we`.
  - `mem_addr` = winner's address with bits [1:0] forced to 0.
  - `mem_wdata` = `d_wdata`.
  - When no grant is given, `mem_we` = 0.
- Response FSM; it tracks the previous cycle's read owner:
  - IDLE: no read outstanding.
  - RESP_F: a fetch read was issued last cycle; the byte lane `f_addr[1:0]` is latched at grant.
  - RESP_D: a data read was issued last cycle.
  - Transitions:
    - Any state -> RESP_F on `f_gnt`.
    - Any state -> RESP_D on `d_gnt` & ~`d_we`.
    - Otherwise -> IDLE; a write grant also goes to IDLE.
  - Back-to-back grants are legal: a response and a new grant occur in the same cycle.
- Responses:
  - In RESP_F: `f_rvalid`=1 and `f_rdata` = `mem_rdata` byte selected by the latched lane, little-endian: lane 0 = [7:0], lane 3 = [31:24].
  - In RESP_D: `d_rvalid`=1 and `d_rdata` = `mem_rdata`.
  - Writes produce no rvalid.
  - rdata outputs are 0 when the corresponding rvalid is 0.
- Reset:
  - State -> IDLE, latched lane -> 0, starve counter -> 0.
  - All outputs are 0 while `reset`=1; gnt is forced low regardless of req.
  - Reset asserted in the cycle after a grant drops the pending response: no rvalid is ever delivered for it.

## Timing
- Grant latency: 0 cycles (combinational) when uncontested.
- Read latency: rvalid exactly 1 cycle after the grant cycle.
- Write: the memory is updated at the rising edge ending the grant cycle.
- Throughput: 1 access per cycle, sustained, with any mix of requesters.
- With guard off and `d_req` held continuously, fetch is starved indefinitely. This is legal by design.
- No combinational path from `mem_rdata` to any gnt or `mem_*` output.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments each cycle `f_req`=1 & `f_gnt`=0, saturating at 15.
  - It clears on `f_gnt` or when `f_req`=0.
  - When counter ≥ `STARVE_LIMIT` and both requesters are active, fetch wins that cycle.
  - After the fetch grant the counter is 0, so data again has priority.
- `MEM_ARB_STARVE_GUARD_EN` undefined:
  - No counter exists and `STARVE_LIMIT` is ignored.
  - Data has strict priority.

## Test plan
- Reset behaviour: `reset`=1 with `f_req`=`d_req`=1 -> all outputs 0. Release reset with only `f_req`, `f_addr`=0x102, `mem_rdata`=0xAABBCCDD -> `f_gnt`=1, `mem_addr`=0x100; next cycle `f_rvalid`=1, `f_rdata`=0xBB.
- Data write then read: `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678 -> `mem_we`=1 and no `d_rvalid`. Next cycle a read of 0x40 -> `d_rvalid`=1 one cycle later with `d_rdata`=0x12345678.
- Contention, guard undefined: both requesters held for 10 cycles -> `d_gnt`=1 every cycle, `f_gnt`=0 throughout.
- Contention, guard defined, `STARVE_LIMIT`=4: both held -> `f_gnt` on cycle 5, then `d_gnt` on cycles 6–9, then `f_gnt` on cycle 10.
- Interleaved back-to-back reads: F, D, F on consecutive cycles -> `f_rvalid`, `d_rvalid`, `f_rvalid` on the three following cycles, each with the correct data and byte lane.
- Reset mid-response: grant a fetch read, then assert `reset` the next cycle -> `f_rvalid` stays 0, and after release the state is IDLE.
